// File: rtl/ascon_pack.sv
// Shared types and round constants for the ASCON permutation round counter.
package ascon_pack;

  typedef enum logic {
    RCNT_IDLE = 1'b0,
    RCNT_RUN  = 1'b1
  } rcnt_state_t;

  localparam int ROUND_START_P12 = 0;
  localparam int ROUND_START_P8  = 4;
  localparam int ROUND_START_P6  = 6;
  localparam int ROUND_LAST      = 11;

endpackage

// File: rtl/ascon_round_counter.sv
// ASCON permutation round counter: per-mode start round, counts up to LAST under en_i.
// Optional sticky protocol-error flag enabled by defining ASCON_RCNT_ERR_EN.
module ascon_round_counter
  import ascon_pack::*;
#(
  parameter int WIDTH   = 4,
  parameter int LAST    = ROUND_LAST,
  parameter int N_MODES = 3,
  parameter logic [N_MODES*WIDTH-1:0] START_TABLE = {4'(ROUND_START_P6),
                                                     4'(ROUND_START_P8),
                                                     4'(ROUND_START_P12)},
  localparam int MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              en_i,
  input  logic              abort_i,
  output logic [WIDTH-1:0]  cpt_o,
  output logic              busy_o,
  output logic              last_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [WIDTH-1:0] LAST_L    = LAST[WIDTH-1:0];
  localparam logic [MODE_W:0]  N_MODES_L = N_MODES[MODE_W:0];

  if (LAST >= (1 << WIDTH)) begin : g_bad_last
    $fatal(1, "ascon_round_counter: LAST does not fit in WIDTH bits");
  end
  for (genvar k = 0; k < N_MODES; k++) begin : g_chk_start
    if (START_TABLE[k*WIDTH +: WIDTH] > LAST) begin : g_bad_start
      $fatal(1, "ascon_round_counter: START_TABLE entry exceeds LAST");
    end
  end

  rcnt_state_t      state, state_n;
  logic [WIDTH-1:0] cpt_n, start_val;
  logic             done_n, mode_ok;

  assign mode_ok = ({1'b0, mode_i} < N_MODES_L);

  always_comb begin
    start_val = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if ({1'b0, mode_i} == (MODE_W+1)'(k)) start_val = START_TABLE[k*WIDTH +: WIDTH];
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cpt_n   = cpt_o;
    done_n  = 1'b0;
    if (abort_i) begin
      state_n = RCNT_IDLE;
      cpt_n   = '0;
    end else begin
      case (state)
        RCNT_IDLE: begin
          if (start_i && mode_ok) begin
            state_n = RCNT_RUN;
            cpt_n   = start_val;
          end
        end
        RCNT_RUN: begin
          if (en_i) begin
            // The final round parks the index at LAST rather than wrapping.
            if (cpt_o == LAST_L) begin
              state_n = RCNT_IDLE;
              done_n  = 1'b1;
            end else begin
              cpt_n = cpt_o + 1'b1;
            end
          end
        end
        default: state_n = RCNT_IDLE;
      endcase
    end
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state  <= RCNT_IDLE;
      cpt_o  <= '0;
      done_o <= 1'b0;
    end else begin
      state  <= state_n;
      cpt_o  <= cpt_n;
      done_o <= done_n;
    end
  end

  assign busy_o = (state == RCNT_RUN);
  assign last_o = (state == RCNT_RUN) && (cpt_o == LAST_L);

`ifdef ASCON_RCNT_ERR_EN
  logic err_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if ((start_i && ((state == RCNT_RUN) || !mode_ok)) ||
                 (en_i && (state == RCNT_IDLE))) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_round_counter.sv
// Self-checking bench for ascon_round_counter: directed scenarios plus random
// stimulus compared every cycle against a round-number model kept in the bench.
module tb_ascon_round_counter;
  import ascon_pack::*;

  localparam int WIDTH   = 4;
  localparam int LAST    = 11;
  localparam int N_MODES = 3;

  logic             clk = 1'b0;
  logic             reset, start, en, abort;
  logic [1:0]       mode;
  logic [WIDTH-1:0] cpt;
  logic             busy, last, done, err;

  ascon_round_counter dut (
    .clock_i (clk),
    .reset_i (reset),
    .start_i (start),
    .mode_i  (mode),
    .en_i    (en),
    .abort_i (abort),
    .cpt_o   (cpt),
    .busy_o  (busy),
    .last_o  (last),
    .done_o  (done),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a run is "active" with an integer round number.
  int start_tab[N_MODES] = '{0, 4, 6};
  bit m_run, m_done, m_err;
  int m_round, m_run_start, m_en_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_run   <= 1'b0;
      m_round <= 0;
      m_done  <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_done <= 1'b0;
`ifdef ASCON_RCNT_ERR_EN
      if ((start && (m_run || int'(mode) >= N_MODES)) || (en && !m_run)) m_err <= 1'b1;
`endif
      if (abort) begin
        m_run   <= 1'b0;
        m_round <= 0;
      end else if (!m_run) begin
        if (start && int'(mode) < N_MODES) begin
          m_run       <= 1'b1;
          m_round     <= start_tab[int'(mode)];
          m_run_start <= start_tab[int'(mode)];
          m_en_cnt    <= 0;
        end
      end else if (en) begin
        m_en_cnt <= m_en_cnt + 1;
        if (m_round == LAST) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_round <= m_round + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cpt",  int'(cpt),  m_round);
      check("busy", int'(busy), int'(m_run));
      check("last", int'(last), int'(m_run && m_round == LAST));
      check("done", int'(done), int'(m_done));
      check("err",  int'(err),  int'(m_err));
      if (done) check("run_len", m_en_cnt, LAST - m_run_start + 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, ens;
    bit seen;
    reset = 1'b1; start = 1'b0; en = 1'b0; abort = 1'b0; mode = 2'd0;

    // 1. reset for two cycles
    step(); chk_on = 1'b1;
    step();
    @(negedge clk);
    check("rst_cpt", int'(cpt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    reset = 1'b0;

    // 2. mode 0 with continuous enable: 0..11, then done
    start = 1'b1; mode = 2'd0; step();
    start = 1'b0; en = 1'b1;
    for (int i = 0; i <= LAST; i++) begin
      @(negedge clk);
      check("m0_cpt", int'(cpt), i);
      check("m0_busy", int'(busy), 1);
      check("m0_last", int'(last), int'(i == LAST));
      step();
    end
    en = 1'b0;
    @(negedge clk);
    check("m0_done", int'(done), 1);
    check("m0_idle_cpt", int'(cpt), LAST);
    step();
    @(negedge clk);
    check("m0_done_pulse", int'(done), 0);

    // Invalid mode in IDLE: nothing changes
    start = 1'b1; mode = 2'd3; step(); start = 1'b0;
    @(negedge clk);
    check("bad_mode_busy", int'(busy), 0);
    check("bad_mode_cpt", int'(cpt), LAST);

    // 3. mode 2 with en toggling: 6 enabled edges, done after the 6th
    start = 1'b1; mode = 2'd2; step(); start = 1'b0;
    @(negedge clk);
    check("m2_cpt_start", int'(cpt), 6);
    seen = 1'b0; ens = 0; cyc = 0;
    while (cyc < 40 && !seen) begin
      en = (cyc % 2 == 0);
      if (en) ens++;
      step();
      @(negedge clk);
      if (done) seen = 1'b1; else cyc++;
    end
    en = 1'b0;
    check("m2_done_seen", int'(seen), 1);
    check("m2_enabled", ens, 6);
    check("m2_cycles", cyc, 10);

    // 4. mode 1, abort at cpt 7 together with en
    step();
    start = 1'b1; mode = 2'd1; step(); start = 1'b0; en = 1'b1;
    step(); step(); step();
    @(negedge clk);
    check("m1_cpt7", int'(cpt), 7);
    abort = 1'b1; step(); abort = 1'b0; en = 1'b0;
    @(negedge clk);
    check("abort_cpt", int'(cpt), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    start = 1'b1; mode = 2'd1; step(); start = 1'b0; en = 1'b1;
    @(negedge clk);
    check("restart_cpt", int'(cpt), 4);
    for (int i = 0; i < 8; i++) step();
    en = 1'b0;
    @(negedge clk);
    check("restart_done", int'(done), 1);

    // 5. start in RUN at cpt 3 is ignored
    step();
    start = 1'b1; mode = 2'd0; step(); start = 1'b0; en = 1'b1;
    step(); step(); step();
    start = 1'b1; mode = 2'd2; step(); start = 1'b0;
    @(negedge clk);
    check("ign_start_cpt", int'(cpt), 4);
    check("ign_start_busy", int'(busy), 1);

    // 6. reset at cpt 9, then back-to-back start in the done cycle
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    check("pre_rst_cpt", int'(cpt), 9);
    reset = 1'b1; step(); reset = 1'b0; en = 1'b0;
    @(negedge clk);
    check("mid_rst_cpt", int'(cpt), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    start = 1'b1; mode = 2'd2; step(); start = 1'b0; en = 1'b1;
    seen = 1'b0; cyc = 0;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1; else begin step(); cyc++; end
    end
    check("b2b_done_seen", int'(seen), 1);
    start = 1'b1; mode = 2'd0; en = 1'b0; step(); start = 1'b0;
    @(negedge clk);
    check("b2b_cpt", int'(cpt), 0);
    check("b2b_busy", int'(busy), 1);

    // Random phase, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(3) == 0);
      mode  = 2'($urandom_range(3));
      en    = ($urandom_range(1) == 0);
      abort = ($urandom_range(31) == 0);
      reset = ($urandom_range(199) == 0);
      step();
    end
    reset = 1'b0; start = 1'b0; en = 1'b0; abort = 1'b0;
    step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
